// File: rtl/game_flow_controller.sv
// Game-level sequencer for the tank shooter: attract/play/game-over flow, lives, score, high score.
// Define GAME_FLOW_PAUSE_EN to add a PAUSED state driven by the pause_req level.
module game_flow_controller #(
  parameter int LIVES_INIT      = 3,
  parameter int LIVES_W         = 2,
  parameter int SCORE_W         = 16,
  parameter int SCORE_STEP      = 1,
  parameter int GAMEOVER_FRAMES = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               start_hit,
  input  logic               target_reach,
  input  logic               pause_req,
  output logic               game_started,
  output logic               game_over,
  output logic               round_start,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [SCORE_W-1:0] display_score,
  output logic               new_high
);

  localparam logic [1:0] S_ATTRACT   = 2'd0;
  localparam logic [1:0] S_PLAYING   = 2'd1;
  localparam logic [1:0] S_GAME_OVER = 2'd2;
  localparam logic [1:0] S_PAUSED    = 2'd3;

  localparam int GO_W = (GAMEOVER_FRAMES > 1) ? $clog2(GAMEOVER_FRAMES) : 1;
  localparam logic [GO_W-1:0]    GO_LAST     = GO_W'(GAMEOVER_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);
  localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  logic [1:0]         state;
  logic [GO_W-1:0]    go_cnt;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_inc;
  logic               pause_go;

  // One spare bit catches the carry so the score saturates instead of wrapping.
  assign score_sum = {1'b0, score} + (SCORE_W + 1)'(SCORE_STEP);
  assign score_inc = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

`ifdef GAME_FLOW_PAUSE_EN
  assign pause_go = pause_req;
`else
  logic unused_pause_req;
  assign unused_pause_req = pause_req;
  assign pause_go         = 1'b0;
`endif

  assign game_started  = (state != S_ATTRACT);
  assign game_over     = (state == S_GAME_OVER);
  assign display_score = (state == S_ATTRACT) ? high_score : score;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_ATTRACT;
      lives       <= LIVES_START;
      score       <= '0;
      high_score  <= '0;
      go_cnt      <= '0;
      new_high    <= 1'b0;
      round_start <= 1'b0;
    end else begin
      round_start <= 1'b0;
      if (frame_tick) begin
        case (state)
          S_ATTRACT: begin
            if (start_hit) begin
              state       <= S_PLAYING;
              score       <= '0;
              lives       <= LIVES_START;
              round_start <= 1'b1;
            end
          end
          S_PLAYING: begin
            if (pause_go) begin
              state <= S_PAUSED;
            end else begin
              score <= score_inc;
              if (target_reach) begin
                lives <= lives - 1'b1;
                // new_high is judged against the final score, including this tick's increment.
                if (lives == LIVES_ONE) begin
                  state    <= S_GAME_OVER;
                  go_cnt   <= '0;
                  new_high <= (score_inc > high_score);
                end
              end
            end
          end
          S_GAME_OVER: begin
            if (go_cnt == GO_LAST) begin
              state      <= S_ATTRACT;
              high_score <= (score > high_score) ? score : high_score;
              score      <= '0;
              lives      <= LIVES_START;
              go_cnt     <= '0;
              new_high   <= 1'b0;
            end else begin
              go_cnt <= go_cnt + 1'b1;
            end
          end
`ifdef GAME_FLOW_PAUSE_EN
          S_PAUSED: begin
            if (!pause_req) state <= S_PLAYING;
          end
`endif
          default: state <= S_ATTRACT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller against a frame-level reference model.
// Honours GAME_FLOW_PAUSE_EN the same way as the design.
module tb_game_flow_controller;

  localparam int LIVES_INIT      = 3;
  localparam int LIVES_W         = 2;
  localparam int SCORE_W         = 8;
  localparam int SCORE_STEP      = 1;
  localparam int GAMEOVER_FRAMES = 4;
  localparam int SCORE_MAX       = (1 << SCORE_W) - 1;

  logic               clk;
  logic               resetn;
  logic               frame_tick;
  logic               start_hit;
  logic               target_reach;
  logic               pause_req;
  logic               game_started;
  logic               game_over;
  logic               round_start;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [SCORE_W-1:0] display_score;
  logic               new_high;

  int checks = 0;
  int errors = 0;

  typedef enum {M_ATTRACT, M_PLAYING, M_OVER, M_PAUSED} mode_t;
  mode_t m_mode;
  int    m_lives, m_score, m_high, m_go;
  bit    m_rs;

  game_flow_controller #(
    .LIVES_INIT(LIVES_INIT), .LIVES_W(LIVES_W), .SCORE_W(SCORE_W),
    .SCORE_STEP(SCORE_STEP), .GAMEOVER_FRAMES(GAMEOVER_FRAMES)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start_hit(start_hit),
    .target_reach(target_reach), .pause_req(pause_req), .game_started(game_started),
    .game_over(game_over), .round_start(round_start), .lives(lives), .score(score),
    .high_score(high_score), .display_score(display_score), .new_high(new_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    m_mode  = M_ATTRACT;
    m_lives = LIVES_INIT;
    m_score = 0;
    m_high  = 0;
    m_go    = 0;
    m_rs    = 1'b0;
  endtask

  // One frame of game rules, expressed as plain integer bookkeeping.
  task automatic modelTick(input bit start, input bit reach, input bit pause);
    bit pause_on;
`ifdef GAME_FLOW_PAUSE_EN
    pause_on = pause;
`else
    pause_on = 1'b0;
`endif
    m_rs = 1'b0;
    case (m_mode)
      M_ATTRACT: if (start) begin
        m_mode = M_PLAYING; m_score = 0; m_lives = LIVES_INIT; m_rs = 1'b1;
      end
      M_PLAYING: begin
        if (pause_on) m_mode = M_PAUSED;
        else begin
          m_score = (m_score + SCORE_STEP > SCORE_MAX) ? SCORE_MAX : m_score + SCORE_STEP;
          if (reach) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) begin m_mode = M_OVER; m_go = 0; end
          end
        end
      end
      M_OVER: begin
        m_go = m_go + 1;
        if (m_go == GAMEOVER_FRAMES) begin
          if (m_score > m_high) m_high = m_score;
          m_score = 0; m_lives = LIVES_INIT; m_go = 0; m_mode = M_ATTRACT;
        end
      end
      M_PAUSED: if (!pause_on) m_mode = M_PLAYING;
      default: m_mode = M_ATTRACT;
    endcase
  endtask

  task automatic checkVal(input string tag, input string name, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s/%s: observed %0h expected %0h", tag, name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal(tag, "game_started", game_started, (m_mode != M_ATTRACT));
    checkVal(tag, "game_over", game_over, (m_mode == M_OVER));
    checkVal(tag, "round_start", round_start, m_rs);
    checkVal(tag, "lives", lives, m_lives);
    checkVal(tag, "score", score, m_score);
    checkVal(tag, "high_score", high_score, m_high);
    checkVal(tag, "display_score", display_score, (m_mode == M_ATTRACT) ? m_high : m_score);
    if (m_mode != M_OVER)
      checkVal(tag, "new_high", new_high, 0);
    else if (m_go >= 1)
      checkVal(tag, "new_high", new_high, (m_score > m_high));
  endtask

  // Drive one clock with the given inputs, advance the model, then check all outputs.
  task automatic applyStimulus(input bit tick, input bit start, input bit reach,
                               input bit pause, input bit rst_n, input string tag);
    frame_tick   = tick;
    start_hit    = start;
    target_reach = reach;
    pause_req    = pause;
    resetn       = rst_n;
    @(posedge clk);
    #1;
    if (!rst_n) modelReset();
    else if (tick) modelTick(start, reach, pause);
    else m_rs = 1'b0;
    frame_tick   = 1'b0;
    start_hit    = 1'b0;
    target_reach = 1'b0;
    resetn       = 1'b1;
    checkOutput(tag);
  endtask

  task automatic playTicks(input int n, input bit reach, input string tag);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(0, 1, 1, 0, 1, {tag, "_gap"});
      applyStimulus(1, 0, reach, 0, 1, tag);
    end
  endtask

  task automatic playGame(input int final_score, input string tag);
    applyStimulus(1, 1, 0, 0, 1, {tag, "_start"});
    playTicks(final_score - LIVES_INIT, 1'b0, {tag, "_play"});
    playTicks(LIVES_INIT, 1'b1, {tag, "_die"});
    playTicks(GAMEOVER_FRAMES, 1'b1, {tag, "_over"});
  endtask

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; start_hit = 1'b0; target_reach = 1'b0; pause_req = 1'b0;
    modelReset();

    applyStimulus(1, 1, 1, 0, 0, "reset");
    checkVal("reset", "display_zero", display_score, 0);
    applyStimulus(1, 0, 1, 0, 1, "attract_reach");
    applyStimulus(0, 1, 0, 0, 1, "attract_notick");

    applyStimulus(1, 1, 0, 0, 1, "start");
    checkVal("start", "round_start_hi", round_start, 1);
    applyStimulus(0, 0, 0, 0, 1, "rs_drop");
    playTicks(10, 1'b0, "play10");
    checkVal("play10", "score_is_10", score, 10);

    playTicks(12, 1'b0, "play22");
    playTicks(3, 1'b1, "lives");
    checkVal("lives", "lives_zero", lives, 0);
    checkVal("lives", "over_flag", game_over, 1);
    applyStimulus(1, 0, 1, 0, 1, "over_reach4");
    checkVal("over_reach4", "lives_stay0", lives, 0);
    checkVal("over_reach4", "new_high_set", new_high, 1);
    playTicks(GAMEOVER_FRAMES - 1, 1'b0, "over_exit");
    checkVal("over_exit", "high_25", high_score, 25);
    checkVal("over_exit", "display_25", display_score, 25);

    playGame(20, "lower");
    checkVal("lower", "high_kept", high_score, 25);
    playGame(25, "equal");
    checkVal("equal", "high_eq", high_score, 25);
    playGame(31, "higher");
    checkVal("higher", "high_31", high_score, 31);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1, "random");
    end

    applyStimulus(0, 0, 0, 0, 0, "sat_reset");
    applyStimulus(1, 1, 0, 0, 1, "sat_start");
    for (int i = 0; i < SCORE_MAX + 3; i++) applyStimulus(1, 0, 0, 0, 1, "sat");
    checkVal("sat", "score_max", score, SCORE_MAX);

    for (int i = 0; i < 100; i++) applyStimulus(0, i[0], ~i[0], 0, 1, "hold");

`ifdef GAME_FLOW_PAUSE_EN
    applyStimulus(0, 0, 0, 0, 0, "pause_reset");
    applyStimulus(1, 1, 0, 0, 1, "pause_start");
    playTicks(7, 1'b0, "pause_pre");
    applyStimulus(1, 0, 1, 1, 1, "pause_enter");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1, 1, "paused");
    checkVal("paused", "score_7", score, 7);
    checkVal("paused", "lives_3", lives, 3);
    applyStimulus(1, 0, 0, 0, 1, "resume");
    applyStimulus(1, 0, 0, 0, 1, "resume_tick");
    checkVal("resume_tick", "score_8", score, 8);
    applyStimulus(1, 0, 0, 1, 1, "pause_again");
    applyStimulus(1, 0, 0, 1, 0, "pause_reset_mid");
    pause_req = 1'b0;
`endif

    applyStimulus(1, 1, 0, 0, 1, "mid_start");
    playTicks(5, 1'b0, "mid_play");
    applyStimulus(1, 0, 1, 0, 0, "mid_reset");
    checkVal("mid_reset", "score_gone", score, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
